pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Central stall sequencer for the 6-stage pipeline: PC(0) IF(1) ID(2) EX(3) DF(4) WB(5).
//   Merges per-stage stall requests into one STALL vector. Runs the DF-stage data SRAM
//   wait-state FSM. Arbitrates the base RAM, which is shared by instruction fetch and DF
//   data access. The pipeline register between stage i and i+1 takes {STALL[i+1],STALL[i]}.
// PARAMETERS
//   WAIT_CYCLES  2  DF stall cycles per data SRAM access; legal range 1..15
//   CNT_W        4  wait counter width; must satisfy 2**CNT_W > WAIT_CYCLES
// PORTS
//   CLK            in   1  clock; all state updates on posedge
//   RST            in   1  reset; synchronous, active-high
//   IF_STALL_REQ   in   1  instruction SRAM not ready
//   ID_STALL_REQ   in   1  load-use hazard detected in ID
//   EX_STALL_REQ   in   1  multi-cycle EX operation busy
//   DF_MEM_REQ     in   1  load/store currently in DF; held high while DF is stalled
//   DF_MEM_BASE    in   1  DF access targets base RAM (shared with IF)
//   STALL          out  6  bit i = 1: stage i holds (STOP = 1); STALL[5] is always 0
//   BASE_RAM_GRANT out  1  0 = base RAM owned by IF, 1 = owned by DF
//   DF_MEM_DONE    out  1  single-cycle pulse: the DF access completes this cycle
// BEHAVIOUR
//   Reset: while RST = 1, STALL = 0, BASE_RAM_GRANT = 0 and DF_MEM_DONE = 0.
//     On the next edge the FSM enters IDLE, cnt = 0 and base_q = 0.
//     Reset asserted mid-access aborts the access. No DONE pulse is produced.
//   Stage masks (OR-combined into STALL; the highest requesting stage dominates):
//     IF req -> 6'b000011   ID req -> 6'b000111   EX req -> 6'b001111
//     DF active -> 6'b011111   base-RAM hold in DONE -> 6'b000011
//   FSM states: IDLE, ACCESS, DONE.
//     IDLE:   if DF_MEM_REQ = 1, this is stall cycle 1 (DF mask active) and
//             base_q <= DF_MEM_BASE.
//             Next state is DONE if WAIT_CYCLES = 1. Otherwise next state is ACCESS
//             with cnt <= WAIT_CYCLES-1.
//             If DF_MEM_REQ = 0, stay in IDLE.
//     ACCESS: DF mask active; cnt <= cnt-1; go to DONE when cnt = 1.
//             DF_MEM_REQ/BASE are ignored in this state.
//     DONE:   DF mask inactive and DF_MEM_DONE = 1, so the pipeline advances at this edge.
//             Next state is always IDLE. DF_MEM_REQ is ignored here (no re-trigger on the held op).
//   Latency: a DF access stalls for exactly WAIT_CYCLES cycles. The op occupies DF for
//     WAIT_CYCLES+1 cycles.
//   Base RAM grant:
//     BASE_RAM_GRANT = (IDLE & DF_MEM_REQ & DF_MEM_BASE) | ((ACCESS|DONE) & base_q).
//     IF is denied whenever grant = 1, so STALL[1:0] = 2'b11 for those cycles,
//     including the DONE cycle (IF/ID register inserts a bubble).
//   All outputs are combinational from state and inputs. No input-to-state
//     combinational loop.
//   Simultaneous requests: masks OR together. Example: EX req during a DF access
//     yields 011111. An ID req in DONE with base_q = 1 yields 000111.
// TESTING
//   1 Reset with all requests high for 2 cycles -> STALL = 0, grant = 0, done = 0.
//     After release with all requests low -> STALL = 0.
//   2 W=2; DF_MEM_REQ=1, BASE=0 at cycle t -> STALL = 011111 at t and t+1.
//     At t+2: STALL = 0, DONE = 1, grant = 0 throughout.
//   3 W=2; same as test 2 with BASE=1 -> grant = 1 at t..t+2.
//     STALL = 011111 at t and t+1; 000011 at t+2; DONE = 1 at t+2.
//   4 Priority: ID+EX requests same cycle -> 001111. IF only -> 000011.
//     EX during ACCESS -> 011111.
//   5 RST=1 at t+1 during ACCESS -> at t+2 the FSM is IDLE with no DONE pulse.
//     Re-asserted REQ stalls for a full W cycles.
//   6 W=1: REQ at t -> STALL = 011111 at t only; DONE = 1 at t+1; IDLE at t+2.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall sequencer for the 6-stage pipeline PC(0) IF(1) ID(2) EX(3) DF(4) WB(5).
// Merges per-stage stall requests into a single STALL vector. Runs the DF data SRAM
// wait-state FSM. Arbitrates the base RAM, which instruction fetch and DF data access share.
// The pipeline register between stage i and i+1 is controlled by {STALL[i+1], STALL[i]}.
module pipe_stall_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,  // DF stall cycles per data access, 1..15
  parameter int unsigned CNT_W       = 4   // 2**CNT_W must exceed WAIT_CYCLES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IF_STALL_REQ,
  input  logic       ID_STALL_REQ,
  input  logic       EX_STALL_REQ,
  input  logic       DF_MEM_REQ,
  input  logic       DF_MEM_BASE,
  output logic [5:0] STALL,
  output logic       BASE_RAM_GRANT,
  output logic       DF_MEM_DONE
);

  // Each requester holds its own stage and everything upstream of it.
  localparam logic [5:0] MaskIf = 6'b000011;
  localparam logic [5:0] MaskId = 6'b000111;
  localparam logic [5:0] MaskEx = 6'b001111;
  localparam logic [5:0] MaskDf = 6'b011111;

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             base_q, base_d;

  logic             df_active;
  logic             grant_raw;
  logic [5:0]       stall_mask;

  // Next-state logic for the DF wait-state sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    df_active = 1'b0;
    case (state_q)
      StIdle: begin
        if (DF_MEM_REQ) begin
          // First stall cycle of the access; latch which RAM the op targets.
          df_active = 1'b1;
          base_d    = DF_MEM_BASE;
          if (WAIT_CYCLES == 1) begin
            state_d = StDone;
          end else begin
            state_d = StAccess;
            cnt_d   = CntLoad;
          end
        end
      end
      StAccess: begin
        // Request inputs are ignored here; the op is held in DF by the stall.
        df_active = 1'b1;
        cnt_d     = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Pipeline advances at this edge; the still-high request is the same op,
        // so never re-trigger from here.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Base RAM ownership: DF owns it from the first stall cycle through DONE.
  always_comb begin
    grant_raw = 1'b0;
    case (state_q)
      StIdle:   grant_raw = DF_MEM_REQ & DF_MEM_BASE;
      StAccess: grant_raw = base_q;
      StDone:   grant_raw = base_q;
      default:  grant_raw = 1'b0;
    endcase
  end

  // Merge the stall masks; a denied fetch (grant = 1) holds PC and IF, which also
  // covers the DONE cycle where the IF/ID register takes a bubble.
  always_comb begin
    stall_mask = 6'b000000;
    if (IF_STALL_REQ) stall_mask = stall_mask | MaskIf;
    if (ID_STALL_REQ) stall_mask = stall_mask | MaskId;
    if (EX_STALL_REQ) stall_mask = stall_mask | MaskEx;
    if (df_active)    stall_mask = stall_mask | MaskDf;
    if (grant_raw)    stall_mask = stall_mask | MaskIf;
  end

  // Outputs are forced quiet while reset is asserted, even mid-access.
  always_comb begin
    STALL          = RST ? 6'b000000 : stall_mask;
    BASE_RAM_GRANT = ~RST & grant_raw;
    DF_MEM_DONE    = ~RST & (state_q == StDone);
  end

  // WB never stalls.
  a_wb_never_stalls : assert property (@(posedge CLK) STALL[5] == 1'b0);

  // DONE is a single-cycle pulse.
  a_done_pulse : assert property (@(posedge CLK) disable iff (RST)
    DF_MEM_DONE |=> !DF_MEM_DONE);

  // Whenever DF owns the base RAM, fetch must be held.
  a_grant_holds_if : assert property (@(posedge CLK) disable iff (RST)
    BASE_RAM_GRANT |-> (STALL[1:0] == 2'b11));

  // DONE never coincides with the DF stall mask.
  a_done_not_stalled : assert property (@(posedge CLK) disable iff (RST)
    DF_MEM_DONE |-> !STALL[4]);

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: one instance with WAIT_CYCLES = 2 and one
// with WAIT_CYCLES = 1, driven from a per-cycle vector table through a scoreboard queue,
// followed by a bounded hand-written access sequence.
module tb_pipe_stall_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  // WAIT_CYCLES = 2 instance
  logic       rst2, if2, id2, ex2, req2, base2;
  logic [5:0] stall2;
  logic       grant2, done2;

  // WAIT_CYCLES = 1 instance
  logic       rst1, if1, id1, ex1, req1, base1;
  logic [5:0] stall1;
  logic       grant1, done1;

  pipe_stall_ctrl #(
    .WAIT_CYCLES(2),
    .CNT_W      (4)
  ) u_dut_w2 (
    .CLK           (CLK),
    .RST           (rst2),
    .IF_STALL_REQ  (if2),
    .ID_STALL_REQ  (id2),
    .EX_STALL_REQ  (ex2),
    .DF_MEM_REQ    (req2),
    .DF_MEM_BASE   (base2),
    .STALL         (stall2),
    .BASE_RAM_GRANT(grant2),
    .DF_MEM_DONE   (done2)
  );

  pipe_stall_ctrl #(
    .WAIT_CYCLES(1),
    .CNT_W      (2)
  ) u_dut_w1 (
    .CLK           (CLK),
    .RST           (rst1),
    .IF_STALL_REQ  (if1),
    .ID_STALL_REQ  (id1),
    .EX_STALL_REQ  (ex1),
    .DF_MEM_REQ    (req1),
    .DF_MEM_BASE   (base1),
    .STALL         (stall1),
    .BASE_RAM_GRANT(grant1),
    .DF_MEM_DONE   (done1)
  );

  typedef struct {
    bit         w1;
    bit         rst;
    bit         ifr;
    bit         idr;
    bit         exr;
    bit         req;
    bit         base;
    logic [5:0] stall;
    bit         grant;
    bit         done;
  } vec_t;

  typedef struct {
    int         idx;
    bit         w1;
    logic [5:0] stall;
    bit         grant;
    bit         done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic add(input bit w1, input bit rst, input bit ifr, input bit idr, input bit exr,
                     input bit req, input bit base, input logic [5:0] stall, input bit grant,
                     input bit done);
    vec_t v;
    v.w1 = w1; v.rst = rst; v.ifr = ifr; v.idr = idr; v.exr = exr;
    v.req = req; v.base = base; v.stall = stall; v.grant = grant; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic check(input string what, input logic [5:0] act, input logic [5:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b, expected %b", what, act, exp);
    end
  endtask

  // The non-selected instance is parked in reset.
  task automatic drive(input vec_t v);
    if (v.w1) begin
      rst1 = v.rst; if1 = v.ifr; id1 = v.idr; ex1 = v.exr; req1 = v.req; base1 = v.base;
      rst2 = 1'b1; if2 = 1'b0; id2 = 1'b0; ex2 = 1'b0; req2 = 1'b0; base2 = 1'b0;
    end else begin
      rst2 = v.rst; if2 = v.ifr; id2 = v.idr; ex2 = v.exr; req2 = v.req; base2 = v.base;
      rst1 = 1'b1; if1 = 1'b0; id1 = 1'b0; ex1 = 1'b0; req1 = 1'b0; base1 = 1'b0;
    end
  endtask

  initial begin
    int stall_cycles;
    bit seen_done;
    bit grant_ok;

    rst2 = 1'b1; if2 = 1'b0; id2 = 1'b0; ex2 = 1'b0; req2 = 1'b0; base2 = 1'b0;
    rst1 = 1'b1; if1 = 1'b0; id1 = 1'b0; ex1 = 1'b0; req1 = 1'b0; base1 = 1'b0;

    //   w1 rst if id ex req base  stall       grant done
    // Reset with everything requesting, then release idle.
    add(0, 1, 1, 1, 1, 1, 1, 6'b000000, 0, 0);
    add(0, 1, 1, 1, 1, 1, 1, 6'b000000, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // Priority merging of stage requests.
    add(0, 0, 0, 1, 1, 0, 0, 6'b001111, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 6'b000011, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // Data SRAM access, W = 2.
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // Base RAM access, W = 2; BASE changes after cycle 1 must be ignored.
    add(0, 0, 0, 0, 0, 1, 1, 6'b011111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b000011, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // EX request during ACCESS.
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // ID request in DONE with base RAM held.
    add(0, 0, 0, 0, 0, 1, 1, 6'b011111, 1, 0);
    add(0, 0, 0, 0, 0, 1, 1, 6'b011111, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 6'b000111, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // Reset during ACCESS aborts; re-asserted request stalls a full W cycles.
    add(0, 0, 0, 0, 0, 1, 1, 6'b011111, 1, 0);
    add(0, 1, 0, 0, 0, 1, 1, 6'b000000, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    // W = 1 instance.
    add(1, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 6'b011111, 1, 0);
    add(1, 0, 0, 0, 0, 1, 1, 6'b000011, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 6'b011111, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 6'b000000, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    foreach (vecs[i]) begin
      exp_t e;
      @(posedge CLK);
      #1;
      drive(vecs[i]);
      e.idx = i; e.w1 = vecs[i].w1; e.stall = vecs[i].stall;
      e.grant = vecs[i].grant; e.done = vecs[i].done;
      sb_q.push_back(e);
      @(negedge CLK);
      if (sb_q.size() == 0) begin
        check("scoreboard empty", 6'd1, 6'd0);
      end else begin
        exp_t x;
        x = sb_q.pop_front();
        if (x.w1) begin
          check($sformatf("vec%0d w1 STALL", x.idx), stall1, x.stall);
          check($sformatf("vec%0d w1 GRANT", x.idx), {5'b0, grant1}, {5'b0, x.grant});
          check($sformatf("vec%0d w1 DONE", x.idx), {5'b0, done1}, {5'b0, x.done});
        end else begin
          check($sformatf("vec%0d w2 STALL", x.idx), stall2, x.stall);
          check($sformatf("vec%0d w2 GRANT", x.idx), {5'b0, grant2}, {5'b0, x.grant});
          check($sformatf("vec%0d w2 DONE", x.idx), {5'b0, done2}, {5'b0, x.done});
        end
      end
    end

    // Held base-RAM request on the W = 2 instance: bounded wait for DONE, counting
    // DF stall cycles and checking the grant stays with DF throughout.
    @(posedge CLK);
    #1;
    rst1 = 1'b1; req1 = 1'b0; base1 = 1'b0;
    rst2 = 1'b0; if2 = 1'b0; id2 = 1'b0; ex2 = 1'b0; req2 = 1'b1; base2 = 1'b1;
    stall_cycles = 0;
    seen_done    = 1'b0;
    grant_ok     = 1'b1;
    for (int c = 0; c < 8 && !seen_done; c++) begin
      @(negedge CLK);
      if (!grant2) grant_ok = 1'b0;
      if (done2) seen_done = 1'b1;
      else if (stall2 == 6'b011111) stall_cycles++;
      @(posedge CLK);
      #1;
    end
    req2 = 1'b0; base2 = 1'b0;
    check("seq DONE seen within budget", {5'b0, seen_done}, 6'd1);
    check("seq DF stall cycle count", 6'(stall_cycles), 6'd2);
    check("seq grant held through access", {5'b0, grant_ok}, 6'd1);
    @(negedge CLK);
    check("seq back to IDLE STALL", stall2, 6'b000000);
    check("seq back to IDLE DONE", {5'b0, done2}, 6'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
